// File: rtl/map_scroll_ctrl_pkg.sv
// Shared scroll types: direction encoding, scroll FSM states and offset width.
package map_scroll_ctrl_pkg;

  localparam int MAP_OFS_W = 8;

  typedef enum logic [1:0] {
    DIR_NONE  = 2'b00,
    DIR_RIGHT = 2'b01,
    DIR_LEFT  = 2'b10
  } dir_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCEL  = 2'd1,
    CRUISE = 2'd2
  } state_e;

  // A requested speed of zero still scrolls one column per frame.
  function automatic logic [2:0] eff_speed_f(input logic [2:0] speed);
    return (speed == 3'd0) ? 3'd1 : speed;
  endfunction

endpackage

// File: rtl/map_scroll_ctrl_edge_detect.sv
// Rising-edge detector: one-cycle pulse on the cycle a synchronous input goes high.
module map_scroll_ctrl_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic sig,
  output logic rise
);

  logic sig_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sig_q <= 1'b0;
    else        sig_q <= sig;
  end

  assign rise = sig & ~sig_q;

endmodule

// File: rtl/map_scroll_ctrl.sv
// Frame-synchronous horizontal scroll controller for the map renderer.
// Optional build macro MAP_SCROLL_AUTO_EN enables slow auto-scroll while idle.
module map_scroll_ctrl
  import map_scroll_ctrl_pkg::*;
#(
  parameter int MAX_OFS    = 255,
  parameter int ACC_FRAMES = 4,
  parameter int AUTO_DIV   = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 vblnk,
  input  logic [1:0]           scroll_dir,
  input  logic [2:0]           speed,
  input  logic                 pause,
  input  logic                 load_en,
  input  logic [7:0]           load_val,
  output logic [MAP_OFS_W-1:0] map_ofset,
  output logic                 frame_tick,
  output logic                 at_left,
  output logic                 at_right,
  output logic                 moving,
  output logic                 load_busy
);

  localparam int CW = (ACC_FRAMES > 1) ? $clog2(ACC_FRAMES) : 1;
  localparam logic [MAP_OFS_W-1:0] MAX_V = MAP_OFS_W'(MAX_OFS);

  if (MAX_OFS < 1 || MAX_OFS > 255 || ACC_FRAMES < 1 || AUTO_DIV < 1) begin : g_bad_param
    $error("map_scroll_ctrl: illegal parameter value");
  end

  logic                 frame_edge;
  state_e               state, state_nxt;
  logic [2:0]           step, step_nxt;
  logic [CW-1:0]        cnt, cnt_nxt;
  dir_e                 dir_q, dir_nxt;
  dir_e                 dir_in;
  logic                 dir_valid;
  logic [2:0]           eff_speed;
  logic [MAP_OFS_W-1:0] ofs_nxt;
  logic [MAP_OFS_W-1:0] load_q, load_sel;
  logic                 load_busy_q;
  logic [MAP_OFS_W:0]   sum;

  map_scroll_ctrl_edge_detect u_vblnk_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .sig   (vblnk),
    .rise  (frame_edge)
  );

`ifdef MAP_SCROLL_AUTO_EN
  localparam int AW = (AUTO_DIV > 1) ? $clog2(AUTO_DIV) : 1;
  logic [AW-1:0] auto_cnt, auto_nxt;
`endif

  always_comb begin
    dir_valid = (scroll_dir == DIR_RIGHT) || (scroll_dir == DIR_LEFT);
    dir_in    = (scroll_dir == DIR_LEFT) ? DIR_LEFT : DIR_RIGHT;
    eff_speed = eff_speed_f(speed);
    load_sel  = load_en ? load_val : load_q;
    state_nxt = state;
    step_nxt  = step;
    cnt_nxt   = cnt;
    dir_nxt   = dir_q;
    ofs_nxt   = map_ofset;
    sum       = '0;
`ifdef MAP_SCROLL_AUTO_EN
    auto_nxt  = auto_cnt;
`endif
    if (load_en || load_busy_q) begin
      ofs_nxt   = (load_sel > MAX_V) ? MAX_V : load_sel;
      state_nxt = IDLE;
      step_nxt  = '0;
      cnt_nxt   = '0;
`ifdef MAP_SCROLL_AUTO_EN
      auto_nxt  = '0;
`endif
    end else if (!pause) begin
      case (state)
        IDLE: begin
          if (dir_valid) begin
            state_nxt = ACCEL;
            step_nxt  = 3'd1;
            cnt_nxt   = '0;
            dir_nxt   = dir_in;
          end
        end
        ACCEL: begin
          if (!dir_valid) begin
            state_nxt = IDLE;
            step_nxt  = '0;
            cnt_nxt   = '0;
          end else if (dir_in != dir_q) begin
            step_nxt = 3'd1;
            cnt_nxt  = '0;
            dir_nxt  = dir_in;
          end else if (step >= eff_speed) begin
            // Speed was lowered under the current step while accelerating.
            step_nxt  = eff_speed;
            state_nxt = CRUISE;
          end else begin
            if (cnt == CW'(ACC_FRAMES - 1)) begin
              step_nxt = step + 3'd1;
              cnt_nxt  = '0;
            end else begin
              cnt_nxt = cnt + CW'(1);
            end
            if (step_nxt == eff_speed) state_nxt = CRUISE;
          end
        end
        CRUISE: begin
          if (!dir_valid) begin
            state_nxt = IDLE;
            step_nxt  = '0;
            cnt_nxt   = '0;
          end else if (dir_in != dir_q) begin
            state_nxt = ACCEL;
            step_nxt  = 3'd1;
            cnt_nxt   = '0;
            dir_nxt   = dir_in;
          end else if (eff_speed < step) begin
            step_nxt = eff_speed;
          end else if (eff_speed > step) begin
            state_nxt = ACCEL;
            cnt_nxt   = '0;
          end
        end
        default: begin
          state_nxt = IDLE;
          step_nxt  = '0;
          cnt_nxt   = '0;
        end
      endcase

      // Move by the freshly updated step; reaching a map limit ends the scroll.
      if (state_nxt != IDLE) begin
        if (dir_nxt == DIR_RIGHT) begin
          sum = {1'b0, map_ofset} + {6'd0, step_nxt};
          if (sum >= {1'b0, MAX_V}) begin
            ofs_nxt   = MAX_V;
            state_nxt = IDLE;
            step_nxt  = '0;
            cnt_nxt   = '0;
          end else begin
            ofs_nxt = sum[MAP_OFS_W-1:0];
          end
        end else begin
          if (map_ofset <= {5'd0, step_nxt}) begin
            ofs_nxt   = '0;
            state_nxt = IDLE;
            step_nxt  = '0;
            cnt_nxt   = '0;
          end else begin
            ofs_nxt = map_ofset - {5'd0, step_nxt};
          end
        end
      end

`ifdef MAP_SCROLL_AUTO_EN
      if (state == IDLE && !dir_valid) begin
        if (auto_cnt == AW'(AUTO_DIV - 1)) begin
          auto_nxt = '0;
          if (map_ofset < MAX_V) ofs_nxt = map_ofset + 8'd1;
        end else begin
          auto_nxt = auto_cnt + AW'(1);
        end
      end else begin
        auto_nxt = '0;
      end
`endif
    end
  end

  // Load handshake: load_en is a one-cycle strobe that captures load_val and
  // raises load_busy from the next cycle until the frame edge consumes it; a
  // later strobe overwrites the captured value, and a strobe on the edge cycle
  // is applied at that edge without raising load_busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      step        <= '0;
      cnt         <= '0;
      dir_q       <= DIR_NONE;
      map_ofset   <= '0;
      frame_tick  <= 1'b0;
      load_q      <= '0;
      load_busy_q <= 1'b0;
    end else begin
      frame_tick <= frame_edge;
      if (load_en) load_q <= load_val;
      if (frame_edge) begin
        state       <= state_nxt;
        step        <= step_nxt;
        cnt         <= cnt_nxt;
        dir_q       <= dir_nxt;
        map_ofset   <= ofs_nxt;
        load_busy_q <= 1'b0;
      end else if (load_en) begin
        load_busy_q <= 1'b1;
      end
    end
  end

`ifdef MAP_SCROLL_AUTO_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          auto_cnt <= '0;
    else if (frame_edge) auto_cnt <= auto_nxt;
  end
`endif

  assign at_left   = (map_ofset == '0);
  assign at_right  = (map_ofset == MAX_V);
  assign moving    = (state != IDLE);
  assign load_busy = load_busy_q;

endmodule
